freq_input_control: RTL and testbench
=====================================

Name: freq_input_control

Overview:
User-input front end that produces the frequency/scale pair consumed by display_control and the lock-in reference generator. It synchronises and debounces three push-buttons and a 2-bit scale switch. Buttons step a 13-bit target frequency up or down by a selectable step size, saturating at the range limits. A registered frequency/scale pair and a one-cycle update strobe are presented to downstream logic.

Parameters:
FREQUENCY_RANGE, 8192, number of representable frequencies; frequency_out spans 0..FREQUENCY_RANGE-1
DEFAULT_FREQ, 1000, frequency_out value after reset
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a debounced input changes state (the bench uses 4)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
btn_up  input  1  raw push-button, active-high, asynchronous to clk
btn_down  input  1  raw push-button, active-high, asynchronous to clk
btn_step  input  1  raw push-button, active-high; cycles the step size
sw_scale  input  2  raw scale switches, asynchronous to clk
frequency_out  output  13  current target frequency in Hz (drives frequency_in)
scale_out  output  2  debounced scale (drives scale_in)
step_out  output  2  step-size code: 0=1, 1=10, 2=100, 3=1000
update  output  1  one-cycle strobe when frequency_out or scale_out changes

Behaviour:
- Reset, with clk as the only clock and reset synchronous and active-high:
  - frequency_out=DEFAULT_FREQ, scale_out=0, step_out=0, update=0.
  - All synchroniser, debounce-counter, debounced-state and edge registers clear to 0.
  - Reset asserted mid-debounce or mid-hold discards the pending state.
  - A button still held when reset deasserts is not counted as a press until it is released and pressed again.
- Synchronisation: each of the 5 raw bits passes through a 2-flop synchroniser.
- Debounce, one independent counter per bit:
  - While the synchronised value equals the debounced value, the counter is 0.
  - Otherwise the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced value takes the synchronised value and the counter clears.
  - Any glitch back to the debounced value before that point clears the counter.
- Press event: a debounced 0->1 transition produces a one-cycle event pulse. There is no auto-repeat; holding a button gives exactly one event.
- Total latency from a clean raw edge to the event: 2 synchroniser cycles + DEBOUNCE_CYCLES cycles. The output register adds 1 further cycle.
- Step event: step_out increments modulo 4 (3 wraps to 0). frequency_out is unchanged and no update is issued.
- Up event: frequency_out <= min(frequency_out + step, FREQUENCY_RANGE-1).
  - Compute the sum at 15 bits so it cannot wrap.
- Down event: frequency_out <= max(frequency_out - step, 0).
  - Compute signed or with a compare first; no underflow wrap.
- Up and down events in the same cycle: both are ignored; frequency_out holds and there is no update.
- A step event coinciding with an up/down event: the add/subtract uses the old step_out value, and step_out advances in the same cycle.
- scale_out follows the debounced sw_scale with the same 2+DEBOUNCE_CYCLES latency plus 1 output register. Each bit debounces independently.
- update behaviour:
  - update=1 for exactly one cycle, coincident with the first cycle the new frequency_out/scale_out is visible.
  - It fires only if a value actually changed. A saturated up at the maximum gives no update.
  - A frequency change and a scale change in the same cycle give a single update pulse.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset with DEBOUNCE_CYCLES=4 -> frequency_out=1000, scale_out=0, step_out=0, update=0; all hold for 20 cycles with inputs idle.
- Up step of 10:
  - Stimulus: btn_step pulse held 10 cycles, then btn_up held 10 cycles.
  - Response: step_out=1; frequency_out goes 1000->1010 exactly 7 cycles after the btn_up rising edge; a single update pulse.
- Glitch rejection:
  - Stimulus: btn_down pulses 3 cycles high, 3 low, repeated 5 times.
  - Response: no event, frequency_out unchanged, update stays 0.
- Top saturation:
  - Stimulus: frequency_out=8150, step_out=3, up press.
  - Response: frequency_out=8191 with update=1; a second up press gives 8191 and no update.
- Bottom saturation and simultaneous press:
  - Stimulus: frequency_out=5, step_out=1, down press.
  - Response: frequency_out=0.
  - Stimulus: btn_up and btn_down rising in the same cycle.
  - Response: frequency_out unchanged, no update.
- Scale change and mid-operation reset:
  - Stimulus: sw_scale 0->2'b10.
  - Response: scale_out=2 after 7 cycles, with one update pulse.
  - Stimulus: reset asserted 2 cycles into a btn_up debounce.
  - Response: frequency_out=1000 and no later event while btn_up remains held.

Source files
------------

// File: rtl/freq_input_control.sv
// freq_input_control
//   Front end for the user controls. It synchronises and debounces three
//   push-buttons and a 2-bit scale switch. Button presses step a target
//   frequency up or down by a selectable step and saturate at the range
//   limits. It presents a registered frequency/scale pair to downstream logic.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   btn_up/down/step    raw active-high push-buttons (asynchronous)
//   sw_scale[1:0]       raw scale switches (asynchronous)
//   frequency_out[12:0] target frequency, 0..FREQUENCY_RANGE-1
//   scale_out[1:0]      debounced scale
//   step_out[1:0]       step code: 0=1, 1=10, 2=100, 3=1000
//   update              one-cycle strobe when frequency_out or scale_out changes
module freq_input_control #(
  parameter int FREQUENCY_RANGE = 8192,
  parameter int DEFAULT_FREQ    = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_step,
  input  logic [1:0]  sw_scale,
  output logic [12:0] frequency_out,
  output logic [1:0]  scale_out,
  output logic [1:0]  step_out,
  output logic        update
);
  localparam int          CW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [12:0] FMAX  = 13'(FREQUENCY_RANGE - 1);

  // bit 0 = up, 1 = down, 2 = step, 4:3 = scale
  logic [4:0]         raw, sync1, sync2, deb, deb_q;
  logic [4:0][CW-1:0] cnt;
  logic [2:0]         arm;
  logic [1:0]         settle;
  logic [2:0]         press;

  assign raw = {sw_scale, btn_step, btn_down, btn_up};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb_q <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
    end
  end

  // Independent debounce counter per input bit.
  for (genvar i = 0; i < 5; i++) begin : g_deb
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt[i] <= '0;
        deb[i] <= 1'b0;
      end else if (sync2[i] == deb[i]) begin
        cnt[i] <= '0;
      end else if (cnt[i] == LAST) begin
        deb[i] <= sync2[i];
        cnt[i] <= '0;
      end else begin
        cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // A button held through reset must be released before it can produce a
  // press. The synchroniser clears on reset, so its output is only valid
  // after 'settle' has filled. Until then, a button is not armed.
  always_ff @(posedge clk) begin
    if (reset) begin
      settle <= '0;
      arm    <= '0;
    end else begin
      settle <= {settle[0], 1'b1};
      arm    <= arm | ({3{settle[1]}} & ~sync2[2:0]);
    end
  end

  assign press = deb[2:0] & ~deb_q[2:0] & arm;

  logic [12:0] step_val, freq_next;
  logic [14:0] sum;
  logic [1:0]  step_next, scale_next;
  logic        update_next;

  always_comb begin
    step_val = 13'd1;
    case (step_out)
      2'd0: step_val = 13'd1;
      2'd1: step_val = 13'd10;
      2'd2: step_val = 13'd100;
      2'd3: step_val = 13'd1000;
      default: step_val = 13'd1;
    endcase
    sum       = {2'b00, frequency_out} + {2'b00, step_val};
    freq_next = frequency_out;
    // Up and down together cancel. Both branches use the old step_out.
    if (press[0] && !press[1])
      freq_next = (sum > {2'b00, FMAX}) ? FMAX : sum[12:0];
    else if (press[1] && !press[0])
      freq_next = (frequency_out < step_val) ? 13'd0 : frequency_out - step_val;
    step_next   = press[2] ? step_out + 2'd1 : step_out;
    scale_next  = deb[4:3];
    update_next = (freq_next != frequency_out) || (scale_next != scale_out);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frequency_out <= 13'(DEFAULT_FREQ);
      scale_out     <= '0;
      step_out      <= '0;
      update        <= 1'b0;
    end else begin
      frequency_out <= freq_next;
      scale_out     <= scale_next;
      step_out      <= step_next;
      update        <= update_next;
    end
  end
endmodule

// File: tb/tb_freq_input_control.sv
module tb_freq_input_control;
  logic        clk = 1'b0;
  logic        reset;
  logic        btn_up, btn_down, btn_step;
  logic [1:0]  sw_scale;
  logic [12:0] frequency_out;
  logic [1:0]  scale_out, step_out;
  logic        update;

  freq_input_control #(.FREQUENCY_RANGE(8192), .DEFAULT_FREQ(1000), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_step(btn_step),
    .sw_scale(sw_scale), .frequency_out(frequency_out), .scale_out(scale_out),
    .step_out(step_out), .update(update)
  );

  always #5 clk = ~clk;

  typedef struct { int freq; int scale; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  localparam int UP = 0, DOWN = 1, STEP = 2;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      UP:      btn_up   = v;
      DOWN:    btn_down = v;
      default: btn_step = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    tick(10);
    set_btn(b, 1'b0);
    tick(12);
  endtask

  task automatic push(input int f, input int s);
    exp_t e;
    e.freq = f;
    e.scale = s;
    sbq.push_back(e);
  endtask

  // Monitor: every update pulse must match the next expected pair.
  always @(negedge clk) begin
    if (update === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_update: freq %0d scale %0d, required no update", frequency_out, scale_out);
      end else begin
        mon_e = sbq.pop_front();
        if (frequency_out !== 13'(mon_e.freq) || scale_out !== 2'(mon_e.scale)) begin
          errors++;
          $display("FAIL update_value: freq %0d scale %0d, required freq %0d scale %0d",
                   frequency_out, scale_out, mon_e.freq, mon_e.scale);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; btn_up = 0; btn_down = 0; btn_step = 0; sw_scale = 2'b00;
    tick(3);
    reset = 1'b0;

    // Reset state held with idle inputs
    chk("reset_scale", scale_out, 0);
    chk("reset_step", step_out, 0);
    for (int i = 0; i < 20; i++) begin
      chk("reset_freq", frequency_out, 1000);
      tick(1);
    end
    chk("reset_update", update, 0);

    // Step to 10, then up with exact latency check
    press(STEP);
    chk("step_to_1", step_out, 1);
    push(1010, 0);
    btn_up = 1'b1;
    tick(6);
    chk("up_lat_before", frequency_out, 1000);
    tick(1);
    chk("up_lat_after", frequency_out, 1010);
    tick(3);
    btn_up = 1'b0;
    tick(12);

    // Glitch rejection
    for (int i = 0; i < 5; i++) begin
      btn_down = 1'b1; tick(3);
      btn_down = 1'b0; tick(3);
    end
    tick(10);
    chk("glitch_freq", frequency_out, 1010);

    // Climb to 8150 with step 1000 then 10
    press(STEP); press(STEP);
    chk("step_to_3", step_out, 3);
    for (int k = 1; k <= 7; k++) begin
      push(1010 + 1000 * k, 0);
      press(UP);
    end
    press(STEP); press(STEP);
    chk("step_wrap_to_1", step_out, 1);
    for (int k = 1; k <= 14; k++) begin
      push(8010 + 10 * k, 0);
      press(UP);
    end
    chk("at_8150", frequency_out, 8150);
    press(STEP); press(STEP);
    chk("step_to_3b", step_out, 3);
    push(8191, 0);
    press(UP);
    chk("top_sat", frequency_out, 8191);
    press(UP);
    chk("top_sat_hold", frequency_out, 8191);

    // Bottom saturation and simultaneous press
    reset = 1'b1; tick(2); reset = 1'b0; tick(2);
    chk("rst2_freq", frequency_out, 1000);
    chk("rst2_step", step_out, 0);
    press(STEP); press(STEP); press(STEP);
    push(0, 0);
    press(DOWN);
    chk("down_to_0", frequency_out, 0);
    press(STEP);
    for (int k = 1; k <= 5; k++) begin
      push(k, 0);
      press(UP);
    end
    chk("at_5", frequency_out, 5);
    press(STEP);
    chk("step_10", step_out, 1);
    push(0, 0);
    press(DOWN);
    chk("bottom_sat", frequency_out, 0);
    push(10, 0);
    press(UP);
    btn_up = 1'b1; btn_down = 1'b1;
    tick(10);
    btn_up = 1'b0; btn_down = 1'b0;
    tick(12);
    chk("simul_hold", frequency_out, 10);

    // Scale change with latency
    push(10, 2);
    sw_scale = 2'b10;
    tick(6);
    chk("scale_before", scale_out, 0);
    tick(1);
    chk("scale_after", scale_out, 2);
    tick(5);

    // Reset two cycles into a btn_up debounce, button kept held
    btn_up = 1'b1;
    tick(2);
    reset = 1'b1; tick(1); reset = 1'b0;
    push(1000, 2);  // scale re-debounces to the still-set switch
    tick(20);
    chk("held_no_event", frequency_out, 1000);
    btn_up = 1'b0;
    tick(12);
    push(1001, 2);
    press(UP);
    chk("after_release", frequency_out, 1001);
    tick(5);
    chk("sb_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
